// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and datapath:
// FSM states, mux selects, ALU operations, opcodes and R-type functs.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_MA    = 4'd2,
    S_MR    = 4'd3,
    S_MW    = 4'd4,
    S_MWB   = 4'd5,
    S_EXE   = 4'd6,
    S_AWB   = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9,
    S_HALT  = 4'd15
  } state_e;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_DMR  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [2:0] {
    C_MEM,
    C_ALU,
    C_BR,
    C_JMP,
    C_ILL
  } iclass_e;

  // Coarse instruction class that picks the path out of decode.
  function automatic iclass_e classify(input logic [5:0] op, input logic [5:0] funct);
    iclass_e c;
    c = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: c = C_ALU;
          FN_JR:                                   c = C_JMP;
          default:                                 c = C_ILL;
        endcase
      end
      OP_ADDIU, OP_ORI, OP_LUI: c = C_ALU;
      OP_LW, OP_SW:             c = C_MEM;
      OP_BEQ:                   c = C_BR;
      OP_J, OP_JAL:             c = C_JMP;
      default:                  c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: instruction fields and flags in,
// every datapath control strobe and select out.
interface mc_if;
  logic [5:0]  op;
  logic [15:0] Imm;
  logic        Zero;
  logic [1:0]  NPCOp;
  logic        PCWr;
  logic        IRWr;
  logic [1:0]  WDSel;
  logic [1:0]  RegDst;
  logic        RegWr;
  logic        ExtOp;
  logic        ALUSelB;
  logic [2:0]  ALUOp;
  logic        MemWr;
  logic [3:0]  state;

  modport master (
    input  op, Imm, Zero,
    output NPCOp, PCWr, IRWr, WDSel, RegDst, RegWr, ExtOp, ALUSelB, ALUOp, MemWr, state
  );

  modport slave (
    output op, Imm, Zero,
    input  NPCOp, PCWr, IRWr, WDSel, RegDst, RegWr, ExtOp, ALUSelB, ALUOp, MemWr, state
  );
endinterface

// File: rtl/mc_alu_dec.sv
// ALU operand/operation decode from opcode and funct; the controller
// applies these only in the states that actually use the ALU.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       ext_op_o,
  output logic       alu_selb_o
);

  always_comb begin
    alu_op_o   = ALU_ADD;
    ext_op_o   = 1'b0;
    alu_selb_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_SUBU: alu_op_o = ALU_SUB;
          FN_AND:  alu_op_o = ALU_AND;
          FN_OR:   alu_op_o = ALU_OR;
          FN_SLT:  alu_op_o = ALU_SLT;
          default: alu_op_o = ALU_ADD;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        alu_op_o   = ALU_ADD;
        ext_op_o   = 1'b1;
        alu_selb_o = 1'b1;
      end
      OP_ORI: begin
        alu_op_o   = ALU_OR;
        alu_selb_o = 1'b1;
      end
      OP_LUI: begin
        alu_op_o   = ALU_LUI;
        alu_selb_o = 1'b1;
      end
      OP_BEQ:  alu_op_o = ALU_SUB;
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback; only PCWr in the branch state looks at Zero.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic ILLEGAL_NOP = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  mc_if.master  dp_io
);

  state_e     state_q, state_d;
  logic [5:0] op, funct;
  iclass_e    cls;

  logic [2:0] dec_alu_op;
  logic       dec_ext_op, dec_alu_selb;

  logic [1:0] npc_op, wd_sel, reg_dst;
  logic [2:0] alu_op;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, ext_op, alu_selb;

  assign op    = dp_io.op;
  assign funct = dp_io.Imm[5:0];
  assign cls   = classify(op, funct);

  mc_alu_dec u_alu_dec (
    .op_i       (op),
    .funct_i    (funct),
    .alu_op_o   (dec_alu_op),
    .ext_op_o   (dec_ext_op),
    .alu_selb_o (dec_alu_selb)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        case (cls)
          C_MEM:   state_d = S_MA;
          C_ALU:   state_d = S_EXE;
          C_BR:    state_d = S_BR;
          C_JMP:   state_d = S_JMP;
          default: state_d = ILLEGAL_NOP ? S_FETCH : S_HALT;
        endcase
      end
      S_MA:    state_d = (op == OP_SW) ? S_MW : S_MR;
      S_MR:    state_d = S_MWB;
      S_EXE:   state_d = S_AWB;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    npc_op   = NPC_PC4;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    wd_sel   = WD_ALU;
    reg_dst  = RD_RT;
    reg_wr   = 1'b0;
    ext_op   = 1'b0;
    alu_selb = 1'b0;
    alu_op   = ALU_ADD;
    mem_wr   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr = 1'b1;
        pc_wr = 1'b1;
      end
      S_MA, S_EXE: begin
        alu_op   = dec_alu_op;
        ext_op   = dec_ext_op;
        alu_selb = dec_alu_selb;
      end
      S_MW:  mem_wr = 1'b1;
      S_MWB: begin
        reg_wr = 1'b1;
        wd_sel = WD_DMR;
      end
      // ALU controls stay up so ALUOUT is still valid while it is written back.
      S_AWB: begin
        alu_op   = dec_alu_op;
        ext_op   = dec_ext_op;
        alu_selb = dec_alu_selb;
        reg_wr   = 1'b1;
        reg_dst  = (op == OP_RTYPE) ? RD_RD : RD_RT;
      end
      S_BR: begin
        alu_op   = dec_alu_op;
        ext_op   = dec_ext_op;
        alu_selb = dec_alu_selb;
        npc_op   = NPC_BR;
        pc_wr    = dp_io.Zero;
      end
      S_JMP: begin
        pc_wr = 1'b1;
        if (op == OP_RTYPE) begin
          npc_op = NPC_JR;
        end else begin
          npc_op = NPC_J;
          if (op == OP_JAL) begin
            reg_wr  = 1'b1;
            reg_dst = RD_RA;
            wd_sel  = WD_LINK;
          end
        end
      end
      default: ;
    endcase
  end

  // Write strobes are gated by reset so an abandoned instruction writes nothing.
  assign dp_io.PCWr    = pc_wr  & reset;
  assign dp_io.IRWr    = ir_wr  & reset;
  assign dp_io.RegWr   = reg_wr & reset;
  assign dp_io.MemWr   = mem_wr & reset;
  assign dp_io.NPCOp   = npc_op;
  assign dp_io.WDSel   = wd_sel;
  assign dp_io.RegDst  = reg_dst;
  assign dp_io.ExtOp   = ext_op;
  assign dp_io.ALUSelB = alu_selb;
  assign dp_io.ALUOp   = alu_op;
  assign dp_io.state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: two instances (ILLEGAL_NOP=1 and 0) share
// stimulus; per-cycle expected controls come from an instruction-level model.
module tb_mc_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] npc;
    logic       pcwr;
    logic       irwr;
    logic [1:0] wdsel;
    logic [1:0] regdst;
    logic       regwr;
    logic       extop;
    logic       alusel;
    logic [2:0] aluop;
    logic       memwr;
  } rec_t;

  typedef enum int {
    M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_ADDIU, M_ORI, M_LUI,
    M_LW, M_SW, M_BEQ, M_J, M_JAL, M_JR, M_ILL
  } mn_e;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op_v = '0;
  logic [15:0] imm_v = '0;
  logic        zero_v = 1'b0;

  always #5 clk = ~clk;

  mc_if bus0();
  mc_if bus1();

  assign bus0.op = op_v;  assign bus0.Imm = imm_v;  assign bus0.Zero = zero_v;
  assign bus1.op = op_v;  assign bus1.Imm = imm_v;  assign bus1.Zero = zero_v;

  mc_ctrl #(.ILLEGAL_NOP(1'b1)) dut0 (.clk(clk), .reset(reset), .dp_io(bus0.master));
  mc_ctrl #(.ILLEGAL_NOP(1'b0)) dut1 (.clk(clk), .reset(reset), .dp_io(bus1.master));

  rec_t act0, act1;
  assign act0 = {bus0.state, bus0.NPCOp, bus0.PCWr, bus0.IRWr, bus0.WDSel, bus0.RegDst,
                 bus0.RegWr, bus0.ExtOp, bus0.ALUSelB, bus0.ALUOp, bus0.MemWr};
  assign act1 = {bus1.state, bus1.NPCOp, bus1.PCWr, bus1.IRWr, bus1.WDSel, bus1.RegDst,
                 bus1.RegWr, bus1.ExtOp, bus1.ALUSelB, bus1.ALUOp, bus1.MemWr};

  rec_t q0[$];
  rec_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   halted1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit is_rtype(input mn_e m);
    return (m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_JR});
  endfunction

  task automatic encode(input mn_e m, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom_range(0, 63));
    case (m)
      M_ADDU:  begin o = 6'b000000; f = 6'b100001; end
      M_SUBU:  begin o = 6'b000000; f = 6'b100011; end
      M_AND:   begin o = 6'b000000; f = 6'b100100; end
      M_OR:    begin o = 6'b000000; f = 6'b100101; end
      M_SLT:   begin o = 6'b000000; f = 6'b101010; end
      M_JR:    begin o = 6'b000000; f = 6'b001000; end
      M_ADDIU: o = 6'b001001;
      M_ORI:   o = 6'b001101;
      M_LUI:   o = 6'b001111;
      M_LW:    o = 6'b100011;
      M_SW:    o = 6'b101011;
      M_BEQ:   o = 6'b000100;
      M_J:     o = 6'b000010;
      M_JAL:   o = 6'b000011;
      default: begin
        case ($urandom_range(0, 2))
          0:       o = 6'b111111;
          1:       begin o = 6'b000000; f = 6'b000000; end
          default: o = 6'b000001;
        endcase
      end
    endcase
  endtask

  // State walk of one instruction from fetch.
  task automatic get_path(input mn_e m, output int n, output int st[5]);
    st = '{0, 1, 0, 0, 0};
    case (m)
      M_LW:                 begin n = 5; st[2] = 2; st[3] = 3; st[4] = 5; end
      M_SW:                 begin n = 4; st[2] = 2; st[3] = 4; end
      M_BEQ:                begin n = 3; st[2] = 8; end
      M_J, M_JAL, M_JR:     begin n = 3; st[2] = 9; end
      M_ILL:                n = 2;
      default:              begin n = 4; st[2] = 6; st[3] = 7; end
    endcase
  endtask

  // {ALUOp, ALUSelB, ExtOp} for each arithmetic instruction.
  function automatic logic [4:0] alu_of(input mn_e m);
    case (m)
      M_SUBU:  return 5'b001_0_0;
      M_AND:   return 5'b011_0_0;
      M_OR:    return 5'b010_0_0;
      M_SLT:   return 5'b100_0_0;
      M_ADDIU: return 5'b000_1_1;
      M_ORI:   return 5'b010_1_0;
      M_LUI:   return 5'b101_1_0;
      default: return 5'b000_0_0;
    endcase
  endfunction

  function automatic rec_t exp_rec(input mn_e m, input int st, input logic z);
    rec_t r;
    r = '0;
    r.state = 4'(st);
    case (st)
      0: begin r.irwr = 1'b1; r.pcwr = 1'b1; end
      2: begin r.alusel = 1'b1; r.extop = 1'b1; end
      4: r.memwr = 1'b1;
      5: begin r.regwr = 1'b1; r.wdsel = 2'b01; end
      6, 7: begin
        {r.aluop, r.alusel, r.extop} = alu_of(m);
        if (st == 7) begin
          r.regwr  = 1'b1;
          r.regdst = is_rtype(m) ? 2'b01 : 2'b00;
        end
      end
      8: begin r.aluop = 3'b001; r.npc = 2'b01; r.pcwr = z; end
      9: begin
        r.pcwr = 1'b1;
        r.npc  = (m == M_JR) ? 2'b11 : 2'b10;
        if (m == M_JAL) begin r.regwr = 1'b1; r.regdst = 2'b10; r.wdsel = 2'b10; end
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic rec_t no_writes(input rec_t r);
    rec_t x;
    x = r;
    x.pcwr = 1'b0; x.irwr = 1'b0; x.regwr = 1'b0; x.memwr = 1'b0;
    return x;
  endfunction

  function automatic rec_t halt_rec();
    rec_t r;
    r = '0;
    r.state = 4'd15;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  // rst_at: step at which reset goes low for two cycles (-1 = never).
  // zmode: -1 random Zero each cycle, else the fixed Zero value.
  task automatic run_instr(input mn_e m, input int rst_at, input int zmode);
    logic [5:0]  o, f;
    logic [15:0] imm;
    int          n;
    int          st[5];
    rec_t        r;
    encode(m, o, f);
    get_path(m, n, st);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        imm = 16'($urandom);
        imm[5:0] = f;
        op_v = o;
        imm_v = imm;
      end
      zero_v = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      r = exp_rec(m, st[k], zero_v);
      if (k == rst_at) begin
        reset = 1'b0;
        q0.push_back(no_writes(r));
        q1.push_back(halted1 ? halt_rec() : no_writes(r));
        @(posedge clk); #1;
        r = no_writes(exp_rec(m, 0, 1'b0));
        q0.push_back(r);
        q1.push_back(r);
        halted1 = 1'b0;
        return;
      end
      reset = 1'b1;
      q0.push_back(r);
      q1.push_back(halted1 ? halt_rec() : r);
    end
    if (m == M_ILL) halted1 = 1'b1;
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string nm, input rec_t a, input rec_t e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cycle %0d: got state=%0d ctl=%b, expected state=%0d ctl=%b",
               nm, cyc, a.state, a[14:0], e.state, e[14:0]);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check("dut0_nop1", act0, q0.pop_front());
    if (q1.size() > 0) check("dut1_halt", act1, q1.pop_front());
  end

  initial begin
    int   n;
    int   st[5];
    mn_e  m;
    int   ra;
    rec_t r;

    // power-up reset: second reset cycle must show FETCH with no writes
    reset = 1'b0;
    @(posedge clk); #1;
    r = no_writes(exp_rec(M_ADDU, 0, 1'b0));
    q0.push_back(r);
    q1.push_back(r);

    run_instr(M_LW, -1, -1);
    run_instr(M_SLT, -1, -1);
    run_instr(M_BEQ, -1, 1);
    run_instr(M_BEQ, -1, 0);
    run_instr(M_JAL, -1, -1);
    run_instr(M_JR, -1, -1);
    run_instr(M_J, -1, -1);
    run_instr(M_SW, -1, -1);
    run_instr(M_ADDIU, -1, -1);
    run_instr(M_ORI, -1, -1);
    run_instr(M_LUI, -1, -1);
    run_instr(M_ADDU, -1, -1);
    run_instr(M_SUBU, -1, -1);
    run_instr(M_AND, -1, -1);
    run_instr(M_OR, -1, -1);
    run_instr(M_LW, 3, -1);
    run_instr(M_ILL, -1, -1);
    run_instr(M_ADDU, -1, -1);
    run_instr(M_LW, -1, -1);
    run_instr(M_BEQ, -1, 1);
    run_instr(M_SW, 2, -1);
    run_instr(M_JAL, -1, -1);

    for (int i = 0; i < 300; i++) begin
      m = mn_e'($urandom_range(0, 13));
      if ($urandom_range(0, 99) < 8) m = M_ILL;
      get_path(m, n, st);
      ra = -1;
      if ($urandom_range(0, 99) < (halted1 ? 30 : 5)) ra = $urandom_range(0, n - 1);
      run_instr(m, ra, -1);
    end

    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d/%0d expected records left unchecked, required 0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
